// File: rtl/mips_bus_stall_ram.sv
// Wait-state bus RAM for a MIPS core: boot/instruction region at 0xBFC00000 and a data
// region at 0x0, with a programmable per-transfer stall and a sticky protocol error flag.
module mips_bus_stall_ram #(
    parameter string RAM_INIT_FILE = "",
    parameter int    WAIT_CYCLES   = 2,
    parameter int    INSTR_WORDS   = 1024,
    parameter int    DATA_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        err
);

    localparam logic [31:0] IBASE    = 32'hBFC0_0000;
    localparam logic [31:0] ISPAN    = 32'(INSTR_WORDS * 4);
    localparam logic [31:0] DSPAN    = 32'(DATA_WORDS * 4);
    localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);
    localparam int          IW       = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int          DW       = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    logic [31:0] imem [INSTR_WORDS];
    logic [31:0] dmem [DATA_WORDS];

    logic [3:0]  stall_cnt;
    logic [3:0]  eff_cnt;
    logic [31:0] prev_address;
    logic        prev_read;
    logic        prev_write;

    logic        req;
    logic        both;
    logic        changed;
    logic        accept;
    logic        ihit;
    logic        dhit;
    logic [31:0] ioff;
    logic [IW-1:0] iidx;
    logic [DW-1:0] didx;
    logic [31:0] mem_word;

    // A request that changes mid-stall is treated as a fresh request starting at count 0.
    always_comb begin
        req         = read | write;
        both        = read & write;
        changed     = req && (stall_cnt != 4'd0) &&
                      ({address, read, write} != {prev_address, prev_read, prev_write});
        eff_cnt     = changed ? 4'd0 : stall_cnt;
        waitrequest = req && !both && (eff_cnt != WAIT_MAX);
        accept      = req && !waitrequest;
    end

    always_comb begin
        ioff     = address - IBASE;
        ihit     = ioff < ISPAN;
        dhit     = address < DSPAN;
        iidx     = ioff[IW+1:2];
        didx     = address[DW+1:2];
        mem_word = 32'h0;
        if (ihit)
            mem_word = imem[iidx];
        else if (dhit)
            mem_word = dmem[didx];
        readdata = (accept && read && !write) ? mem_word : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= 4'd0;
            prev_address <= 32'h0;
            prev_read    <= 1'b0;
            prev_write   <= 1'b0;
            err          <= 1'b0;
        end else begin
            prev_address <= address;
            prev_read    <= read;
            prev_write   <= write;
            stall_cnt    <= waitrequest ? (eff_cnt + 4'd1) : 4'd0;
            if (changed ||
                (accept && (both || (address[1:0] != 2'b00) || !(ihit || dhit))))
                err <= 1'b1;
        end
    end

    // Memory is deliberately outside the reset domain; reset only blocks an in-flight write.
    always_ff @(posedge clk) begin
        if (reset && accept && write && !read) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    if (ihit)
                        imem[iidx][8*i +: 8] <= writedata[8*i +: 8];
                    else if (dhit)
                        dmem[didx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_stall_ram.sv
// Self-checking bench: random legal traffic against a word-addressed memory model,
// then directed cases for errors, restart-on-change, reset mid-stall and zero wait states.
module tb_mips_bus_stall_ram;

    localparam int          WAIT  = 2;
    localparam logic [31:0] IBASE = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        wr, rd, wait_req, err;
    logic [3:0]  be;
    logic [31:0] addr0, wdata0, rdata0;
    logic        wr0, rd0, wait0, err0;
    logic [3:0]  be0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mdl [bit [31:0]];
    bit          mdl_err;

    mips_bus_stall_ram #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset), .address(addr), .write(wr), .read(rd),
        .waitrequest(wait_req), .writedata(wdata), .byteenable(be),
        .readdata(rdata), .err(err)
    );

    mips_bus_stall_ram #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(addr0), .write(wr0), .read(rd0),
        .waitrequest(wait0), .writedata(wdata0), .byteenable(be0),
        .readdata(rdata0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_addr(input logic [31:0] a);
        if (a >= IBASE && a < IBASE + 32'd4096)
            return 1'b1;
        return a < 32'd4096;
    endfunction

    // Holds one request until accepted, checking stall length, read data and error flag.
    task automatic apply_stimulus(input logic [31:0] a, input logic r, input logic w,
                                  input logic [31:0] d, input logic [3:0] b);
        int          cyc;
        bit [31:0]   key;
        logic [31:0] exp_rd;
        bit          legal;
        addr = a; rd = r; wr = w; wdata = d; be = b;
        key   = a & ~32'h3;
        legal = legal_addr(a);
        cyc   = 0;
        @(negedge clk);
        while (wait_req === 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            @(negedge clk);
        end
        check_output("stall_count", 32'(cyc), (r && w) ? 32'd0 : 32'(WAIT));
        exp_rd = 32'h0;
        if (r && !w && legal)
            exp_rd = mdl.exists(key) ? mdl[key] : 32'hx;
        check_output("readdata", rdata, exp_rd);
        @(posedge clk); #1;
        if (w && !r && legal) begin
            logic [31:0] old;
            old = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (b[i]) old[8*i +: 8] = d[8*i +: 8];
            mdl[key] = old;
        end
        if ((r && w) || a[1:0] != 2'b00 || !legal)
            mdl_err = 1'b1;
        check_output("err", {31'h0, err}, {31'h0, mdl_err});
    endtask

    task automatic go_idle();
        addr = 32'h0; rd = 1'b0; wr = 1'b0; wdata = 32'h0; be = 4'h0;
    endtask

    initial begin
        logic [31:0] pool [8];
        logic [31:0] d0 [4];
        logic [31:0] old20;
        pool = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h3FC,
                 IBASE, IBASE + 32'h4, IBASE + 32'hFFC};
        mdl_err = 1'b0;
        go_idle();
        addr0 = 32'h0; rd0 = 1'b0; wr0 = 1'b0; wdata0 = 32'h0; be0 = 4'h0;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_err", {31'h0, err}, 32'h0);
        check_output("reset_idle_wait", {31'h0, wait_req}, 32'h0);
        check_output("reset_idle_rdata", rdata, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (pool[i])
            apply_stimulus(pool[i], 1'b0, 1'b1, $urandom, 4'hF);
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1)
                apply_stimulus(pool[k], 1'b0, 1'b1, $urandom, 4'($urandom));
            else
                apply_stimulus(pool[k], 1'b1, 1'b0, 32'h0, 4'h0);
        end
        go_idle();
        @(posedge clk); #1;
        @(negedge clk);
        check_output("idle_rdata", rdata, 32'h0);
        @(posedge clk); #1;

        apply_stimulus(IBASE, 1'b0, 1'b1, 32'h3C021234, 4'hF);
        apply_stimulus(IBASE, 1'b1, 1'b0, 32'h0, 4'h0);

        apply_stimulus(32'h10, 1'b0, 1'b1, 32'hAABBCCDD, 4'hF);
        apply_stimulus(32'h10, 1'b0, 1'b1, 32'hEEFF0011, 4'h5);
        apply_stimulus(32'h10, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(32'h10, 1'b0, 1'b1, 32'h12345678, 4'h0);
        apply_stimulus(32'h10, 1'b1, 1'b0, 32'h0, 4'h0);

        // Address change after one stall cycle must restart the stall count.
        addr = 32'h0; rd = 1'b1; wr = 1'b0;
        @(negedge clk);
        check_output("chg_wait0", {31'h0, wait_req}, 32'h1);
        @(posedge clk); #1;
        addr = 32'h4;
        @(negedge clk);
        check_output("chg_wait1", {31'h0, wait_req}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("chg_wait2", {31'h0, wait_req}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("chg_accept", {31'h0, wait_req}, 32'h0);
        check_output("chg_rdata", rdata, mdl[32'h4]);
        @(posedge clk); #1;
        mdl_err = 1'b1;
        check_output("chg_err", {31'h0, err}, 32'h1);

        apply_stimulus(32'h80000000, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(32'h4, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(32'h12, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(32'h400, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(IBASE + 32'h1000, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(IBASE + 32'hFFC, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(32'h3FC, 1'b1, 1'b0, 32'h0, 4'h0);
        apply_stimulus(32'h10, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF);
        apply_stimulus(32'h10, 1'b1, 1'b0, 32'h0, 4'h0);

        // Reset in the middle of a stalled write: write abandoned, err cleared.
        old20 = mdl[32'h20];
        addr = 32'h20; wr = 1'b1; rd = 1'b0; wdata = ~old20; be = 4'hF;
        @(negedge clk);
        check_output("rst_stall_wait", {31'h0, wait_req}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_output("rst_err_clear", {31'h0, err}, 32'h0);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        reset = 1'b1;
        mdl_err = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(32'h20, 1'b1, 1'b0, 32'h0, 4'h0);
        go_idle();

        // Zero-wait instance: back-to-back transfers never stall.
        for (int i = 0; i < 4; i++) begin
            d0[i] = $urandom;
            addr0 = IBASE + 32'(4 * i); wr0 = 1'b1; rd0 = 1'b0; wdata0 = d0[i]; be0 = 4'hF;
            @(negedge clk);
            check_output("w0_wait", {31'h0, wait0}, 32'h0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            addr0 = IBASE + 32'(4 * i); wr0 = 1'b0; rd0 = 1'b1;
            @(negedge clk);
            check_output("w0_rd_wait", {31'h0, wait0}, 32'h0);
            check_output("w0_rdata", rdata0, d0[i]);
            @(posedge clk); #1;
        end
        rd0 = 1'b0;
        @(negedge clk);
        check_output("w0_idle_rdata", rdata0, 32'h0);
        check_output("w0_err", {31'h0, err0}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
